// File: rtl/src_line_loader.sv
// Pulls header+payload transfers off an FWFT source FIFO and writes the payload
// lines to consecutive line addresses of a local memory port.
module src_line_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MAGIC      = 32'h4D535055
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [511:0]          fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [511:0]          mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_magic,
  output logic [15:0]           err_count,
  output logic [31:0]           line_count
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_FLUSH, S_DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] idx;
  logic [15:0]           rem;
  logic                  accept;

  logic [31:0]           hdr_magic;
  logic [ADDR_WIDTH-1:0] hdr_base;
  logic [15:0]           hdr_n;

  assign hdr_magic = fifo_q[31:0];
  assign hdr_base  = fifo_q[32 +: ADDR_WIDTH];
  assign hdr_n     = fifo_q[79:64];

  assign accept = mem_we & mem_ready;
  assign busy   = (state == S_DATA) | (state == S_FLUSH);

  // A payload pop is allowed whenever the write register is free or retiring.
  always_comb begin
    fifo_re = ~fifo_empty & (((state == S_HDR) & en) |
                             ((state == S_DATA) & (~mem_we | mem_ready)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR;
      base       <= '0;
      idx        <= '0;
      rem        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err_magic  <= 1'b0;
      err_count  <= '0;
      line_count <= '0;
    end else begin
      done      <= 1'b0;
      err_magic <= 1'b0;
      if (accept) begin
        line_count <= line_count + 32'd1;
        mem_we     <= 1'b0;
      end
      case (state)
        S_HDR: if (fifo_re) begin
          if (hdr_magic != MAGIC) begin
            err_magic <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end else if (hdr_n == 16'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            base  <= hdr_base;
            idx   <= '0;
            rem   <= hdr_n;
            state <= S_DATA;
          end
        end
        S_DATA: if (fifo_re) begin
          // Loading a new line overrides the retire-clear above.
          mem_we    <= 1'b1;
          mem_wdata <= fifo_q;
          mem_addr  <= base + idx;
          idx       <= idx + 1'b1;
          rem       <= rem - 16'd1;
          if (rem == 16'd1) state <= S_FLUSH;
        end
        S_FLUSH: if (accept) begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: state <= S_HDR;
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
